// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared types, direction constants and floor mask helper for the SCAN car controller
package elevator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MOVE  = 2'd1,
      ST_DOOR  = 2'd2,
      ST_ESTOP = 2'd3
   } state_t;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Floors strictly beyond f in direction dir, limited to the n existing floors.
   function automatic logic [63:0] ahead_mask(input int f, input logic dir, input int n);
      logic [63:0] m;
      m = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < n) m[i] = dir ? (i > f) : (i < f);
      end
      return m;
   endfunction

endpackage

// File: rtl/elevator_req_latch.sv
// rtl/elevator_req_latch.sv - sticky car/hall request latches with served-floor clearing and sweep queries
module elevator_req_latch
   import elevator_pkg::*;
#(
   parameter int N_FLOORS   = 8,
   parameter int FLOOR_BITS = $clog2(N_FLOORS),
   parameter int HOME_FLOOR = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_FLOORS-1:0]   inside_req,
   input  logic [N_FLOORS-1:0]   up_call,
   input  logic [N_FLOORS-1:0]   down_call,
   input  logic [FLOOR_BITS-1:0] eval_floor,
   input  logic                  eval_dir,
   input  logic                  door_entry,
   input  logic                  door_here,
   input  logic                  home_set,
   output logic [N_FLOORS-1:0]   pending,
   output logic                  ahead,
   output logic                  behind,
   output logic                  serve_here,
   output logic                  req_here,
   output logic                  new_req
);

   localparam logic [N_FLOORS-1:0] ONE = 1;

   logic [N_FLOORS-1:0] car_q, up_q, dn_q;
   logic [N_FLOORS-1:0] car_set, up_set, dn_set, here, drop;
   logic [N_FLOORS-1:0] car_eff, up_eff, dn_eff, all_eff;
   logic [N_FLOORS-1:0] car_clr, up_clr, dn_clr, home_vec;
   logic [63:0]         amask, bmask;

   assign car_set  = inside_req;
   assign up_set   = up_call & ~(ONE << (N_FLOORS - 1));
   assign dn_set   = down_call & ~ONE;
   assign here     = ONE << eval_floor;
   // With the door already open at a floor, fresh requests there are consumed on arrival.
   assign drop     = door_here ? here : '0;
   assign home_vec = home_set ? (ONE << HOME_FLOOR) : '0;

   // Arriving pulses join this cycle's evaluation.
   assign car_eff = car_q | (car_set & ~drop);
   assign up_eff  = up_q | (up_set & ~drop);
   assign dn_eff  = dn_q | (dn_set & ~drop);
   assign all_eff = car_eff | up_eff | dn_eff;

   assign amask  = ahead_mask(int'(eval_floor), eval_dir, N_FLOORS);
   assign bmask  = ahead_mask(int'(eval_floor), ~eval_dir, N_FLOORS);
   assign ahead  = |(64'(all_eff) & amask);
   assign behind = |(64'(all_eff) & bmask);

   assign serve_here = car_eff[eval_floor]
                     | (eval_dir ? up_eff[eval_floor] : dn_eff[eval_floor])
                     | (!ahead && (up_eff[eval_floor] || dn_eff[eval_floor]));

   assign req_here = |((car_set | up_set | dn_set) & here);
   assign new_req  = |(car_set | up_set | dn_set);

   assign car_clr = door_entry ? here : '0;
   assign up_clr  = (door_entry && (eval_dir || !ahead)) ? here : '0;
   assign dn_clr  = (door_entry && (!eval_dir || !ahead)) ? here : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         car_q <= '0;
         up_q  <= '0;
         dn_q  <= '0;
      end else begin
         car_q <= (car_q & ~car_clr) | (car_set & ~drop) | home_vec;
         up_q  <= (up_q & ~up_clr) | (up_set & ~drop);
         dn_q  <= (dn_q & ~dn_clr) | (dn_set & ~drop);
      end
   end

   assign pending = car_q | up_q | dn_q;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - single-car SCAN controller: sweep FSM, travel/door/idle timers, registered actuators
module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int N_FLOORS     = 8,
   parameter int FLOOR_BITS   = $clog2(N_FLOORS),
   parameter int MOVE_TIMER   = 16,
   parameter int DOOR_TIMER   = 20,
   parameter int IDLE_TIMEOUT = 100,
   parameter int HOME_FLOOR   = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_FLOORS-1:0]   inside_req,
   input  logic [N_FLOORS-1:0]   up_call,
   input  logic [N_FLOORS-1:0]   down_call,
   input  logic                  door_hold,
   input  logic                  estop,
   output logic [FLOOR_BITS-1:0] current_floor,
   output logic                  motor_up,
   output logic                  motor_down,
   output logic                  door_open,
   output logic                  direction,
   output logic                  busy,
   output logic [N_FLOORS-1:0]   pending
);

   localparam int MW = (MOVE_TIMER > 1) ? $clog2(MOVE_TIMER) : 1;
   localparam int DW = $clog2(DOOR_TIMER + 1);
   localparam int IW = $clog2(IDLE_TIMEOUT + 2);
   localparam logic [MW-1:0]         MOVE_LAST = MW'(MOVE_TIMER - 1);
   localparam logic [DW-1:0]         DOOR_LOAD = DW'(DOOR_TIMER);
   localparam logic [IW-1:0]         IDLE_LAST = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
   localparam logic [FLOOR_BITS-1:0] TOP_FLOOR = FLOOR_BITS'(N_FLOORS - 1);
   localparam logic [FLOOR_BITS-1:0] HOME      = FLOOR_BITS'(HOME_FLOOR);
   localparam logic [FLOOR_BITS-1:0] FLOOR_ONE = FLOOR_BITS'(1);

   state_t                  state, state_n;
   logic                    dir_n, arrive, eval_dir;
   logic [FLOOR_BITS-1:0]   eval_floor;
   logic [MW-1:0]           move_cnt, move_cnt_n;
   logic [DW-1:0]           door_cnt, door_cnt_n;
   logic [IW-1:0]           idle_cnt, idle_cnt_n;
   logic                    door_entry, home_set;
   logic                    ahead, behind, serve_here, req_here, new_req;

   elevator_req_latch #(
      .N_FLOORS   (N_FLOORS),
      .FLOOR_BITS (FLOOR_BITS),
      .HOME_FLOOR (HOME_FLOOR)
   ) u_req (
      .clk        (clk),
      .rst        (rst),
      .inside_req (inside_req),
      .up_call    (up_call),
      .down_call  (down_call),
      .eval_floor (eval_floor),
      .eval_dir   (eval_dir),
      .door_entry (door_entry),
      .door_here  (state == ST_DOOR),
      .home_set   (home_set),
      .pending    (pending),
      .ahead      (ahead),
      .behind     (behind),
      .serve_here (serve_here),
      .req_here   (req_here),
      .new_req    (new_req)
   );

   // On a travel terminal count the decision is made for the floor being reached.
   always_comb begin
      arrive     = (state == ST_MOVE) && (move_cnt == MOVE_LAST);
      eval_floor = current_floor;
      if (arrive) begin
         if (direction == DIR_UP && current_floor != TOP_FLOOR)
            eval_floor = current_floor + FLOOR_ONE;
         else if (direction == DIR_DOWN && current_floor != '0)
            eval_floor = current_floor - FLOOR_ONE;
      end
      eval_dir = (eval_floor == '0) ? DIR_UP :
                 (eval_floor == TOP_FLOOR) ? DIR_DOWN : direction;
   end

   always_comb begin
      state_n    = state;
      dir_n      = direction;
      move_cnt_n = '0;
      door_cnt_n = door_cnt;
      idle_cnt_n = '0;
      door_entry = 1'b0;
      home_set   = 1'b0;
      if (estop) begin
         state_n    = ST_ESTOP;
         idle_cnt_n = idle_cnt;
      end else begin
         case (state)
            ST_IDLE: begin
               if (serve_here) begin
                  state_n    = ST_DOOR;
                  dir_n      = eval_dir;
                  door_entry = 1'b1;
                  door_cnt_n = DOOR_LOAD;
               end else if (ahead) begin
                  state_n = ST_MOVE;
                  dir_n   = eval_dir;
               end else if (behind) begin
                  state_n = ST_MOVE;
                  dir_n   = ~eval_dir;
               end else if (!new_req && IDLE_TIMEOUT != 0) begin
                  if (idle_cnt == IDLE_LAST && current_floor != HOME)
                     home_set = 1'b1;
                  else
                     idle_cnt_n = (idle_cnt == IDLE_LAST) ? idle_cnt : idle_cnt + 1'b1;
               end
            end
            ST_MOVE: begin
               if (arrive) begin
                  dir_n = eval_dir;
                  if (serve_here) begin
                     state_n    = ST_DOOR;
                     door_entry = 1'b1;
                     door_cnt_n = DOOR_LOAD;
                  end else if (!ahead) begin
                     state_n = ST_IDLE;
                  end
               end else begin
                  move_cnt_n = move_cnt + 1'b1;
               end
            end
            ST_DOOR: begin
               if (door_hold || req_here) begin
                  door_cnt_n = DOOR_LOAD;
               end else if (door_cnt <= DW'(1)) begin
                  door_cnt_n = '0;
                  state_n    = ST_IDLE;
               end else begin
                  door_cnt_n = door_cnt - 1'b1;
               end
            end
            default: begin
               idle_cnt_n = idle_cnt;
               if (!estop) state_n = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         current_floor <= '0;
         direction     <= DIR_UP;
         move_cnt      <= '0;
         door_cnt      <= '0;
         idle_cnt      <= '0;
         motor_up      <= 1'b0;
         motor_down    <= 1'b0;
         door_open     <= 1'b0;
      end else begin
         state      <= state_n;
         direction  <= dir_n;
         move_cnt   <= move_cnt_n;
         door_cnt   <= door_cnt_n;
         idle_cnt   <= idle_cnt_n;
         motor_up   <= (state_n == ST_MOVE) && dir_n;
         motor_down <= (state_n == ST_MOVE) && !dir_n;
         door_open  <= (state_n == ST_ESTOP) ? door_open : (state_n == ST_DOOR);
         if (arrive && !estop) current_floor <= eval_floor;
      end
   end

   assign busy = (state != ST_IDLE) || (|pending);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - directed self-checking bench for elevator_scan_ctrl (4 floors)
module tb_elevator_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] inside_req, up_call, down_call;
   logic       door_hold, estop;
   logic [1:0] current_floor;
   logic       motor_up, motor_down, door_open, direction, busy;
   logic [3:0] pending;

   int n_cmp = 0;
   int n_err = 0;

   elevator_scan_ctrl #(
      .N_FLOORS     (4),
      .MOVE_TIMER   (4),
      .DOOR_TIMER   (20),
      .IDLE_TIMEOUT (50),
      .HOME_FLOOR   (0)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .inside_req    (inside_req),
      .up_call       (up_call),
      .down_call     (down_call),
      .door_hold     (door_hold),
      .estop         (estop),
      .current_floor (current_floor),
      .motor_up      (motor_up),
      .motor_down    (motor_down),
      .door_open     (door_open),
      .direction     (direction),
      .busy          (busy),
      .pending       (pending)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; inside_req = '0; up_call = '0; down_call = '0;
      door_hold = 1'b0; estop = 1'b0;
      step(2);
      check("rst_floor", 32'(current_floor), 0);
      check("rst_dir", 32'(direction), 1);
      check("rst_motor", 32'({motor_up, motor_down, door_open}), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_pending", 32'(pending), 0);
      rst = 1'b1;
      step(1);

      // hall down call at floor 2 from floor 0
      down_call = 4'b0100; step(1); down_call = '0;
      check("s1_motor_up_start", 32'(motor_up), 1);
      check("s1_pending", 32'(pending), 4'b0100);
      check("s1_busy", 32'(busy), 1);
      step(3);
      check("s1_floor0_late", 32'(current_floor), 0);
      step(1);
      check("s1_floor1", 32'(current_floor), 1);
      check("s1_still_up", 32'(motor_up), 1);
      step(3);
      check("s1_up_8th", 32'(motor_up), 1);
      step(1);
      check("s1_floor2", 32'(current_floor), 2);
      check("s1_motor_off", 32'(motor_up), 0);
      check("s1_door_open", 32'(door_open), 1);
      check("s1_dn2_cleared", 32'(pending), 0);
      step(19);
      check("s1_door_20th", 32'(door_open), 1);
      step(1);
      check("s1_door_closed", 32'(door_open), 0);
      check("s1_idle", 32'(busy), 0);
      check("s1_dir_up", 32'(direction), 1);

      // at floor 2 going up: down_call[3] and inside_req[0] together
      down_call = 4'b1000; inside_req = 4'b0001; step(1);
      down_call = '0; inside_req = '0;
      check("s3_pending_both", 32'(pending), 4'b1001);
      check("s3_up_first", 32'(motor_up), 1);
      step(4);
      check("s3_floor3", 32'(current_floor), 3);
      check("s3_pending_after3", 32'(pending), 4'b0001);
      check("s3_dir_down", 32'(direction), 0);
      check("s3_door3", 32'(door_open), 1);
      step(20);
      check("s3_door3_closed", 32'(door_open), 0);
      step(1);
      check("s3_motor_down", 32'(motor_down), 1);
      step(12);
      check("s3_floor0", 32'(current_floor), 0);
      check("s3_door0", 32'(door_open), 1);
      check("s3_pending_empty", 32'(pending), 0);
      check("s3_dir_forced_up", 32'(direction), 1);
      step(20);

      // inside_req[3] then up_call[1] during travel: stop at 1 first
      inside_req = 4'b1000; step(1); inside_req = '0;
      check("s2_motor_up", 32'(motor_up), 1);
      up_call = 4'b0010; step(1); up_call = '0;
      check("s2_pending", 32'(pending), 4'b1010);
      step(3);
      check("s2_stop_floor1", 32'(current_floor), 1);
      check("s2_door1", 32'(door_open), 1);
      check("s2_pending_keep3", 32'(pending), 4'b1000);

      // door_hold for 30 cycles, then re-press inside_req[1]
      door_hold = 1'b1; step(30); door_hold = 1'b0;
      check("s4_held_open", 32'(door_open), 1);
      step(10);
      inside_req = 4'b0010; step(1); inside_req = '0;
      check("s4_repress_latch0", 32'(pending), 4'b1000);
      step(9);
      check("s4_reloaded_open", 32'(door_open), 1);
      step(10);
      check("s4_last_open", 32'(door_open), 1);
      step(1);
      check("s4_closed", 32'(door_open), 0);
      step(9);
      check("s2_floor3", 32'(current_floor), 3);
      check("s2_door3", 32'(door_open), 1);
      check("s2_pending_empty", 32'(pending), 0);

      // idle at floor 3 parks at home after 50 cycles
      step(20);
      check("s6_idle3", 32'(door_open), 0);
      step(49);
      check("s6_not_yet", 32'(pending), 0);
      step(1);
      check("s6_home_req", 32'(pending), 4'b0001);
      check("s6_busy", 32'(busy), 1);
      step(1);
      check("s6_motor_down", 32'(motor_down), 1);
      step(5);
      check("s6_floor2", 32'(current_floor), 2);
      rst = 1'b0; #1;
      check("s6_rst_floor", 32'(current_floor), 0);
      check("s6_rst_outs", 32'({motor_up, motor_down, door_open}), 0);
      check("s6_rst_pending", 32'(pending), 0);
      check("s6_rst_busy", 32'(busy), 0);
      #1 rst = 1'b1;
      step(1);

      // estop two cycles into a move 0->1
      inside_req = 4'b0010; step(1); inside_req = '0;
      check("s5_move", 32'(motor_up), 1);
      step(1);
      estop = 1'b1; step(1);
      check("s5_estop_motor", 32'({motor_up, motor_down}), 0);
      check("s5_estop_floor", 32'(current_floor), 0);
      inside_req = 4'b1000; step(1); inside_req = '0;
      check("s5_pending_capture", 32'(pending), 4'b1010);
      step(2);
      estop = 1'b0; step(1);
      check("s5_idle_after", 32'(motor_up), 0);
      step(4);
      check("s5_full_timer", 32'({motor_up, current_floor}), 32'b100);
      step(1);
      check("s5_floor1", 32'(current_floor), 1);
      check("s5_door1", 32'(door_open), 1);
      check("s5_pending_left", 32'(pending), 4'b1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
